// File: rtl/mem_arbiter.sv
// Two requesters (A, B) sharing one single-port RAM through a three-state grant FSM.
// Optional ARB_FIXED_PRIO_EN: A wins every idle tie instead of round-robin alternation.
module mem_arbiter #(
  parameter int AW = 3,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reqA,
  input  logic          reqB,
  input  logic          rwA,
  input  logic          rwB,
  input  logic [AW-1:0] AddrA,
  input  logic [AW-1:0] AddrB,
  input  logic [DW-1:0] DataInA,
  input  logic [DW-1:0] DataInB,
  output logic          gntA,
  output logic          gntB,
  output logic          validA,
  output logic          validB,
  output logic [DW-1:0] DataOutA,
  output logic [DW-1:0] DataOutB
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACC_A = 2'd1;
  localparam logic [1:0] ACC_B = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          valid_a_q, valid_a_d;
  logic          valid_b_q, valid_b_d;
  logic [DW-1:0] dout_a_q, dout_a_d;
  logic [DW-1:0] dout_b_q, dout_b_d;
  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          tie_to_a;

`ifdef ARB_FIXED_PRIO_EN
  // No service history is kept: an idle tie always goes to A.
  assign tie_to_a = 1'b1;
`else
  // last_b_q is the last-served pointer (1 = B); reset leaves it at B so A wins the first tie.
  logic last_b_q, last_b_d;

  assign tie_to_a = last_b_q;

  always_comb begin
    last_b_d = last_b_q;
    if (state_q == ACC_A)      last_b_d = 1'b0;
    else if (state_q == ACC_B) last_b_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) last_b_q <= 1'b1;
    else     last_b_q <= last_b_d;
  end
`endif

  // The port just served is masked, so the same port is never granted twice in a row.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (reqA && reqB) state_d = tie_to_a ? ACC_A : ACC_B;
        else if (reqA)    state_d = ACC_A;
        else if (reqB)    state_d = ACC_B;
      end
      ACC_A:   if (reqB) state_d = ACC_B;
      ACC_B:   if (reqA) state_d = ACC_A;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_a_d = (state_q == ACC_A) && !rwA;
    valid_b_d = (state_q == ACC_B) && !rwB;
    dout_a_d  = valid_a_d ? mem_q[AddrA] : dout_a_q;
    dout_b_d  = valid_b_d ? mem_q[AddrB] : dout_b_q;
    wr_en     = ((state_q == ACC_A) && rwA) || ((state_q == ACC_B) && rwB);
    wr_addr   = (state_q == ACC_B) ? AddrB : AddrA;
    wr_data   = (state_q == ACC_B) ? DataInB : DataInA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      dout_a_q  <= '0;
      dout_b_q  <= '0;
    end else begin
      state_q   <= state_d;
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
      dout_a_q  <= dout_a_d;
      dout_b_q  <= dout_b_d;
    end
  end

  // Storage is never cleared, but reset still blocks a write granted in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign gntA     = (state_q == ACC_A);
  assign gntB     = (state_q == ACC_B);
  assign validA   = valid_a_q;
  assign validB   = valid_b_q;
  assign DataOutA = dout_a_q;
  assign DataOutB = dout_b_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter AW, default 3, address width in bits.
REQ-002 The module SHALL have parameter DW, default 4, data width in bits.
REQ-003 Port clk, input, 1: single system clock; all logic SHALL act on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Ports reqA, reqB, input, 1: access request from requester A, B.
REQ-006 Ports rwA, rwB, input, 1: access type; 1 = write, 0 = read.
REQ-007 Ports AddrA, AddrB, input, AW: word address.
REQ-008 Ports DataInA, DataInB, input, DW: write data.
REQ-009 Ports gntA, gntB, output, 1: grant; the access executes in the cycle it is high.
REQ-010 Ports validA, validB, output, 1: read data valid pulse.
REQ-011 Ports DataOutA, DataOutB, output, DW: read data, registered.

Function
REQ-012 The block SHALL contain one single-port storage array of 2^AW words of DW bits, shared by A and B.
REQ-013 The FSM SHALL have three states: IDLE, ACC_A, ACC_B.
REQ-014 gntA SHALL be high only in ACC_A, and gntB only in ACC_B; at most one grant SHALL be high in any cycle.
REQ-015 A requester SHALL hold req, rw, Addr and DataIn stable from req rise until the cycle gnt is high; the arbiter SHALL sample them in that grant cycle.
REQ-016 In ACC_X with rwX=1, DataInX SHALL be written to Addr X at the closing clock edge.
REQ-017 In ACC_X with rwX=0, the word at AddrX SHALL be loaded into DataOutX, and validX SHALL be high for exactly the next cycle. Read latency is one cycle after grant.
REQ-018 A write SHALL never assert valid.
REQ-019 DataOutX SHALL hold its value until the next read granted to X.
REQ-020 In IDLE, next-state selection SHALL be:
- only reqA high -> ACC_A
- only reqB high -> ACC_B
- both high -> port opposite to the last-served pointer
- neither high -> IDLE
REQ-021 In ACC_X, reqX SHALL be masked for next-state selection: go to ACC_Y if reqY is high, else go to IDLE. The same port is never granted in consecutive cycles.
REQ-022 The last-served pointer SHALL update to X at the end of every ACC_X cycle.
REQ-023 Back-to-back alternation A,B,A,B… SHALL occur with no IDLE cycle while both requests stay high.
REQ-024 Addresses SHALL use all AW bits, with no wrap or bounds logic. Storage contents SHALL not be reset.
REQ-025 A read in a later cycle SHALL return data written in any earlier cycle by either port.

Reset
REQ-026 When rst is high at a rising edge:
- state SHALL become IDLE
- gntA, gntB, validA, validB SHALL become 0
- DataOutA, DataOutB SHALL become 0
- the last-served pointer SHALL become B, so A wins the first tie
REQ-027 rst SHALL take priority over everything else: an access in progress in the same cycle SHALL NOT write storage and SHALL NOT produce a valid pulse.

Configuration
REQ-028 Macro ARB_FIXED_PRIO_EN:
- defined: in IDLE with both requests high, A SHALL always win, and the last-served pointer SHALL be ignored
- undefined: round-robin per REQ-020; REQ-021 masking SHALL apply in both builds

Verification
REQ-029 Reset, then idle 3 cycles -> all gnt and valid are 0, DataOut = 0.
REQ-030 A writes 4'b1001 at addr 2, then A reads addr 2 -> gntA in one cycle each; validA one cycle after the read grant with DataOutA = 4'b1001.
REQ-031 B writes 4'b1010 at addr 3, then B reads addr 2 and addr 3 -> DataOutB = 4'b1001, then 4'b1010; each with a validB pulse.
REQ-032 reqA and reqB rise together from IDLE, both reads, held high -> grants go A, B, A, B on consecutive cycles; a tie after B was last served goes to A (RR); with ARB_FIXED_PRIO_EN, A wins every IDLE tie.
REQ-033 A write to addr 5 with rst asserted in the grant cycle, then a write of 4'b0011 to addr 5, then a read of addr 5 -> the aborted write did not commit; the read returns 4'b0011; no valid pulse in the reset cycle.
REQ-034 Same-cycle requests: A writes 4'b0110 at addr 1 while B reads addr 1 -> A granted first, B next cycle; DataOutB = 4'b0110.
